// File: rtl/pwm_io_expander_pkg.sv
// Shared constants and types for the SPI-controlled PWM I/O expander.
// Register map: channel c occupies bytes 6*c .. 6*c+5, big-endian pairs
// for SWITCH, COUNT and PRESCALE.
package pwm_io_expander_pkg;

    localparam int NUM_CH        = 4;
    localparam int REG_W         = 16;
    localparam int BYTES_PER_CH  = 6;
    localparam int REGFILE_BYTES = NUM_CH * BYTES_PER_CH;

    localparam int OFS_SW_HI  = 0;
    localparam int OFS_SW_LO  = 1;
    localparam int OFS_CNT_HI = 2;
    localparam int OFS_CNT_LO = 3;
    localparam int OFS_PRE_HI = 4;
    localparam int OFS_PRE_LO = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } spi_state_e;

    // Byte address of a given field byte of a channel.
    function automatic int rf_idx(input int ch, input int ofs);
        return ch * BYTES_PER_CH + ofs;
    endfunction

endpackage

// File: rtl/pwm_io_expander_if.sv
// SPI bus bundle for the expander.
//   cs_n : chip select, active low (host -> expander)
//   sclk : SPI clock, idle low, mode 0 (host -> expander)
//   mosi : data to expander, MSB first (host -> expander)
//   miso : data from expander, MSB first (expander -> host)
interface pwm_io_expander_if;
    logic cs_n;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (output cs_n, output sclk, output mosi, input miso);
    modport slave  (input cs_n, input sclk, input mosi, output miso);
endinterface

// File: rtl/pwm_io_expander_pwm_channel.sv
// One PWM channel: prescaler, period counter, active-copy reload, compare.
//   clk, rst : system clock, asynchronous active-high reset
//   sw_i     : SWITCH value from the register file
//   cnt_i    : COUNT (period - 1) value from the register file
//   pre_i    : PRESCALE value from the register file
//   pwm_o    : registered PWM output
module pwm_channel
    import pwm_io_expander_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] sw_i,
    input  logic [REG_W-1:0] cnt_i,
    input  logic [REG_W-1:0] pre_i,
    output logic             pwm_o
);

    logic [REG_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [REG_W-1:0] per_cnt_q, per_cnt_d;
    logic [REG_W-1:0] act_sw_q, act_cnt_q, act_pre_q;
    logic             pwm_q;
    logic             tick, wrap, reload;

    always_comb begin
        // >= rather than == keeps the counters bounded if a reload shrinks
        // PRESCALE/COUNT below the running counter value.
        tick      = (pre_cnt_q >= act_pre_q);
        wrap      = tick && (per_cnt_q >= act_cnt_q);
        // An idle channel (COUNT=0) follows the register file continuously;
        // otherwise new values only take effect at a period boundary.
        reload    = wrap || (act_cnt_q == '0);
        pre_cnt_d = tick ? '0 : pre_cnt_q + REG_W'(1);
        per_cnt_d = per_cnt_q;
        if (wrap) begin
            per_cnt_d = '0;
        end else if (tick) begin
            per_cnt_d = per_cnt_q + REG_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
            per_cnt_q <= '0;
            act_sw_q  <= '0;
            act_cnt_q <= '0;
            act_pre_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            per_cnt_q <= per_cnt_d;
            if (reload) begin
                act_sw_q  <= sw_i;
                act_cnt_q <= cnt_i;
                act_pre_q <= pre_i;
            end
            pwm_q <= (per_cnt_q < act_sw_q);
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_io_expander.sv
// SPI-slave-controlled NUM_CH-channel PWM generator (I/O expander).
//   clk, rst : system clock, asynchronous active-high reset
//   spi      : SPI slave bundle (cs_n, sclk, mosi in; miso out), asynchronous
//              inputs synchronised into clk
//   pwm_o    : one PWM output bit per channel
// First byte of a frame sets the address pointer; each following byte is
// written at the pointer, which then auto-increments. MISO returns the byte
// at the pointer during each data byte.
module pwm_io_expander
    import pwm_io_expander_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    pwm_io_expander_if.slave  spi,
    output logic [NUM_CH-1:0] pwm_o
);

    localparam int AW = $clog2(REGFILE_BYTES);

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   cs_prev_q, sclk_prev_q;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall;

    spi_state_e  state_q, state_d;
    logic        frame_active, load_ptr, wr_byte;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  rx_shift_q, tx_q, ptr_q, ptr_next, rd_byte;
    logic        byte_done_q;
    logic [7:0]  rf_q [REGFILE_BYTES];

    // ---------------- input synchronisers and edge detect ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_s;

    // ---------------- framing FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cs_fall) state_d = ST_ADDR;
            ST_ADDR: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                end else if (load_ptr) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: if (cs_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_active = (state_q != ST_IDLE) && !cs_s;
        load_ptr     = byte_done_q && frame_active && (state_q == ST_ADDR);
        wr_byte      = byte_done_q && frame_active && (state_q == ST_DATA);
    end

    // ---------------- receive shifter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            byte_done_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            if (!frame_active) begin
                // Outside a frame any partial byte is dropped.
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
            end else if (sclk_rise) begin
                rx_shift_q  <= {rx_shift_q[6:0], mosi_s};
                bit_cnt_q   <= bit_cnt_q + 3'd1;
                byte_done_q <= (bit_cnt_q == 3'd7);
            end
        end
    end

    // ---------------- pointer, readback and transmit shifter ----------------
    always_comb begin
        ptr_next = load_ptr ? rx_shift_q : ptr_q + 8'd1;
        rd_byte  = '0;
        if (ptr_next < 8'(REGFILE_BYTES)) begin
            rd_byte = rf_q[ptr_next[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            tx_q  <= '0;
        end else if (load_ptr || wr_byte) begin
            ptr_q <= ptr_next;
            tx_q  <= rd_byte;
        end else if (!frame_active) begin
            tx_q <= '0;
        end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
            // The falling edge right after a byte boundary is skipped: the
            // freshly loaded MSB must stay on MISO for the next rising edge.
            tx_q <= {tx_q[6:0], 1'b0};
        end
    end

    assign spi.miso = frame_active && (state_q == ST_DATA) && tx_q[7];

    // ---------------- register file ----------------
    // Out-of-range pointers match no entry, so those writes are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGFILE_BYTES; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_byte) begin
            for (int i = 0; i < REGFILE_BYTES; i++) begin
                if (ptr_q == 8'(i)) begin
                    rf_q[i] <= rx_shift_q;
                end
            end
        end
    end

    // ---------------- PWM channels ----------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        pwm_channel u_ch (
            .clk   (clk),
            .rst   (rst),
            .sw_i  ({rf_q[rf_idx(gi, OFS_SW_HI)],  rf_q[rf_idx(gi, OFS_SW_LO)]}),
            .cnt_i ({rf_q[rf_idx(gi, OFS_CNT_HI)], rf_q[rf_idx(gi, OFS_CNT_LO)]}),
            .pre_i ({rf_q[rf_idx(gi, OFS_PRE_HI)], rf_q[rf_idx(gi, OFS_PRE_LO)]}),
            .pwm_o (pwm_o[gi])
        );
    end

endmodule

// File: tb/tb_pwm_io_expander.sv
module tb_pwm_io_expander;
    import pwm_io_expander_pkg::*;

    localparam int H = 6;   // SPI half period in CLK cycles

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] pwm_o;

    pwm_io_expander_if spi_if ();

    pwm_io_expander #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .spi   (spi_if),
        .pwm_o (pwm_o)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int hi_cnt   [NUM_CH];
    int rise_cnt [NUM_CH];

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_if.mosi = tx[i];
            clks(H);
            rx[i] = spi_if.miso;
            spi_if.sclk = 1'b1;
            clks(H);
            spi_if.sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_if.cs_n = 1'b0;
        clks(H);
    endtask

    task automatic cs_high();
        clks(H);
        spi_if.cs_n = 1'b1;
        clks(2 * H);
    endtask

    task automatic write_regs(input logic [7:0] addr, input logic [47:0] data, input int n);
        logic [7:0] d;
        cs_low();
        spi_byte(addr, d);
        for (int i = 0; i < n; i++) begin
            spi_byte(data[47 - 8*i -: 8], d);
        end
        cs_high();
    endtask

    // Reads a byte without writing it: the 8th rising edge of the data byte
    // is never issued, so the partial byte is discarded at frame end.
    task automatic read_reg(input logic [7:0] addr, output logic [7:0] val);
        logic [7:0] d;
        cs_low();
        spi_byte(addr, d);
        for (int i = 7; i >= 0; i--) begin
            spi_if.mosi = 1'b0;
            clks(H);
            val[i] = spi_if.miso;
            if (i != 0) begin
                spi_if.sclk = 1'b1;
                clks(H);
                spi_if.sclk = 1'b0;
            end
        end
        cs_high();
    endtask

    task automatic measure(input int n);
        logic [NUM_CH-1:0] prev;
        for (int c = 0; c < NUM_CH; c++) begin
            hi_cnt[c]   = 0;
            rise_cnt[c] = 0;
        end
        @(negedge clk);
        prev = pwm_o;
        repeat (n) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (pwm_o[c]) hi_cnt[c]++;
                if (pwm_o[c] && !prev[c]) rise_cnt[c]++;
            end
            prev = pwm_o;
        end
    endtask

    task automatic check_ch(input string tag, input int c, input int hi, input int rise);
        check_vec($sformatf("%s_ch%0d_high", tag, c), 32'(hi_cnt[c]), 32'(hi));
        check_vec($sformatf("%s_ch%0d_rises", tag, c), 32'(rise_cnt[c]), 32'(rise));
    endtask

    task automatic check_rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] v;
        read_reg(addr, v);
        check_vec($sformatf("%s_rd%0d", tag, addr), 32'(v), 32'(exp));
    endtask

    initial begin
        logic [7:0] d;
        rst         = 1'b1;
        spi_if.cs_n = 1'b1;
        spi_if.sclk = 1'b0;
        spi_if.mosi = 1'b0;
        clks(3);
        check_vec("reset_pwm", 32'(pwm_o), 32'h0);
        check_vec("reset_miso", 32'(spi_if.miso), 32'h0);
        rst = 1'b0;
        clks(5);

        // Channel 0: SWITCH=3 COUNT=9 PRESCALE=0 -> 3 high of every 10.
        write_regs(8'h00, 48'h0003_0009_0000, 6);
        clks(50);
        measure(200);
        check_ch("ch0w", 0, 60, 20);
        check_ch("ch0w", 1, 0, 0);
        check_ch("ch0w", 2, 0, 0);
        check_ch("ch0w", 3, 0, 0);
        check_vec("idle_miso", 32'(spi_if.miso), 32'h0);

        // Channel 1: SWITCH=3 COUNT=9 PRESCALE=4 -> period 50, high 15.
        write_regs(8'h06, 48'h0003_0009_0004, 6);
        clks(200);
        measure(200);
        check_ch("ch1w", 0, 60, 20);
        check_ch("ch1w", 1, 60, 4);

        // Partial write: channel 1 PRESCALE lo -> 0, period back to 10.
        write_regs(8'h0B, 48'h0000_0000_0000, 1);
        clks(200);
        measure(200);
        check_ch("part", 1, 60, 20);
        check_ch("part", 0, 60, 20);

        // Aborted frame after 5 data bits must not write.
        cs_low();
        spi_byte(8'h01, d);
        for (int i = 0; i < 5; i++) begin
            spi_if.mosi = 1'b1;
            clks(H);
            spi_if.sclk = 1'b1;
            clks(H);
            spi_if.sclk = 1'b0;
        end
        cs_high();
        check_rd("abort", 8'h01, 8'h03);
        check_rd("abort", 8'h03, 8'h09);

        // SWITCH > COUNT -> constant high.
        write_regs(8'h00, 48'h0010_0000_0000, 2);
        clks(50);
        measure(200);
        check_ch("swgt", 0, 200, 0);

        // Write to address 24 is dropped; 0x17 still takes its byte.
        write_regs(8'h17, 48'h07AA_0000_0000, 2);
        check_rd("a24", 8'h17, 8'h07);
        check_rd("a24", 8'd24, 8'h00);
        check_rd("a24", 8'h00, 8'h00);

        // Auto-increment across the channel 0/1 boundary.
        write_regs(8'h06, 48'h7F00_0000_0000, 1);
        check_rd("inc_pre", 8'h06, 8'h7F);
        write_regs(8'h05, 48'h0200_0000_0000, 2);
        check_rd("inc", 8'h05, 8'h02);
        check_rd("inc", 8'h06, 8'h00);
        clks(100);
        measure(60);
        check_ch("inc", 0, 60, 0);

        // Asynchronous reset in the middle of a frame.
        check_vec("prerst_pwm0", 32'(pwm_o[0]), 32'h1);
        spi_if.cs_n = 1'b0;
        clks(H);
        for (int i = 0; i < 3; i++) begin
            spi_if.mosi = 1'b1;
            clks(H);
            spi_if.sclk = 1'b1;
            clks(H);
            spi_if.sclk = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check_vec("midrst_pwm", 32'(pwm_o), 32'h0);
        check_vec("midrst_miso", 32'(spi_if.miso), 32'h0);
        clks(3);
        spi_if.cs_n = 1'b1;
        spi_if.sclk = 1'b0;
        spi_if.mosi = 1'b0;
        clks(2);
        rst = 1'b0;
        measure(1000);
        for (int c = 0; c < NUM_CH; c++) begin
            check_ch("postrst", c, 0, 0);
        end
        for (int a = 0; a <= REGFILE_BYTES; a++) begin
            check_rd("postrst", 8'(a), 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
